detector_input_conditioner: RTL and testbench



---
 rtl/detector_input_conditioner_pkg.sv | 10 +
 rtl/detector_input_conditioner_if.sv | 26 ++
 rtl/detector_input_conditioner_sync_debounce.sv | 44 ++++
 rtl/detector_input_conditioner.sv | 127 ++++++++++++
 tb/tb_detector_input_conditioner.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/detector_input_conditioner_pkg.sv
// Shared types and constants for the intersection controller input side.
package tl_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} emerg_state_t;

  localparam int CLK_FREQ_HZ             = 50_000_000;
  // 10 ms of stable level at the system clock rate
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100;

endpackage

// File: rtl/detector_input_conditioner_if.sv
// Detector pins, FSM acknowledgements and conditioned outputs in one bundle.
interface detector_input_conditioner_if;

  logic tick_1hz;
  logic ns_raw;
  logic ew_raw;
  logic emerg_raw;
  logic ns_served;
  logic ew_served;
  logic ns_call;
  logic ew_call;
  logic emerg_req;
  logic ns_stuck;
  logic ew_stuck;

  modport master (
    output tick_1hz, ns_raw, ew_raw, emerg_raw, ns_served, ew_served,
    input  ns_call, ew_call, emerg_req, ns_stuck, ew_stuck
  );

  modport slave (
    input  tick_1hz, ns_raw, ew_raw, emerg_raw, ns_served, ew_served,
    output ns_call, ew_call, emerg_req, ns_stuck, ew_stuck
  );

endinterface

// File: rtl/detector_input_conditioner_sync_debounce.sv
// Multi-flop synchroniser followed by a restart-on-bounce level debouncer.
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic d
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   d_reg;
  logic                   s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // Any sample that agrees with the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_reg   <= 1'b0;
      cnt_reg <= '0;
    end else if (s == d_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      d_reg   <= s;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign d = d_reg;

endmodule

// File: rtl/detector_input_conditioner.sv
// Detector front end: debounced call latches and stretched preemption request.
// Optional stuck-detector recall is built when DETECTOR_STUCK_DETECT_EN is defined.
module detector_input_conditioner
  import tl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int EMERG_HOLD      = 2,
  parameter int STUCK_TIME      = 120
) (
  input logic                          clk,
  input logic                          rst,
  detector_input_conditioner_if.slave  bus
);

  localparam int HW = (EMERG_HOLD > 1) ? $clog2(EMERG_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((EMERG_HOLD > 0) ? EMERG_HOLD - 1 : 0);

  logic [2:0] raw_vec;
  logic [2:0] d_vec;
  logic [1:0] served_vec;
  logic [1:0] stuck_vec;
  logic [1:0] call_reg;
  logic [1:0] call_next;

  emerg_state_t    state_reg, state_next;
  logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;

  assign raw_vec    = {bus.emerg_raw, bus.ew_raw, bus.ns_raw};
  assign served_vec = {bus.ew_served, bus.ns_served};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_in
      sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_sync_debounce (
        .clk (clk),
        .rst (rst),
        .raw (raw_vec[gi]),
        .d   (d_vec[gi])
      );
    end

    for (gi = 0; gi < 2; gi++) begin : g_dir
`ifdef DETECTOR_STUCK_DETECT_EN
      localparam int TW = (STUCK_TIME > 0) ? $clog2(STUCK_TIME + 1) : 1;
      localparam logic [TW-1:0] TIMER_MAX = TW'(STUCK_TIME);
      logic [TW-1:0] timer_reg;
      logic          stuck_reg;

      // Timer saturates at the threshold; the flag stays set until reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          timer_reg <= '0;
          stuck_reg <= 1'b0;
        end else begin
          if (!d_vec[gi])
            timer_reg <= '0;
          else if (bus.tick_1hz && (timer_reg != TIMER_MAX))
            timer_reg <= timer_reg + 1'b1;
          stuck_reg <= stuck_reg | (timer_reg == TIMER_MAX);
        end
      end

      assign stuck_vec[gi] = stuck_reg;
`else
      assign stuck_vec[gi] = 1'b0;
`endif
      // Clear only once the vehicle has left and the approach has been served.
      assign call_next[gi] = d_vec[gi] | stuck_vec[gi] |
                             (call_reg[gi] & ~(served_vec[gi] & ~d_vec[gi]));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) call_reg <= '0;
    else     call_reg <= call_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (d_vec[2]) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!d_vec[2]) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      end
      HOLD: begin
        // A fresh request wins over hold expiry in the same cycle.
        if (d_vec[2]) begin
          state_next    = ACTIVE;
          hold_cnt_next = '0;
        end else if (EMERG_HOLD == 0) begin
          state_next = IDLE;
        end else if (bus.tick_1hz) begin
          if (hold_cnt_reg == HOLD_LAST) state_next = IDLE;
          else                           hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ns_call   = call_reg[0];
  assign bus.ew_call   = call_reg[1];
  assign bus.emerg_req = (state_reg != IDLE);
  assign bus.ns_stuck  = stuck_vec[0];
  assign bus.ew_stuck  = stuck_vec[1];

endmodule

// File: tb/tb_detector_input_conditioner.sv
// Directed bench for detector_input_conditioner with short debounce/hold settings.
module tb_detector_input_conditioner;

`ifdef DETECTOR_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic exp_stuck;

  detector_input_conditioner_if bus ();

  detector_input_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .EMERG_HOLD      (2),
    .STUCK_TIME      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1;
    cyc(1);
    bus.tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    cyc(3);
    total++;
    if ({bus.ns_call, bus.ew_call, bus.emerg_req, bus.ns_stuck, bus.ew_stuck} !== 5'b0) begin
      $display("FAIL reset_held outputs=%b want 00000",
               {bus.ns_call, bus.ew_call, bus.emerg_req, bus.ns_stuck, bus.ew_stuck});
      bad++;
    end
    rst = 1'b0;
    cyc(2);
    total++;
    if ({bus.ns_call, bus.ew_call, bus.emerg_req, bus.ns_stuck, bus.ew_stuck} !== 5'b0) begin
      $display("FAIL reset_release outputs=%b want 00000",
               {bus.ns_call, bus.ew_call, bus.emerg_req, bus.ns_stuck, bus.ew_stuck});
      bad++;
    end
    $display("test_reset done");
  endtask

  task automatic test_glitch();
    bus.ns_raw = 1'b1;
    cyc(3);
    bus.ns_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      total++;
      if (bus.ns_call !== 1'b0) begin
        $display("FAIL glitch_ns_call cycle=%0d got=%b want=0", i, bus.ns_call);
        bad++;
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_clean_press();
    bus.ns_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      total++;
      if (bus.ns_call !== 1'b0) begin
        $display("FAIL press_early edge=%0d got=%b want=0", k, bus.ns_call);
        bad++;
      end
    end
    cyc(1);
    total++;
    if (bus.ns_call !== 1'b1) begin
      $display("FAIL press_edge7 got=%b want=1", bus.ns_call);
      bad++;
    end
    bus.ns_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      total++;
      if (bus.ns_call !== 1'b1) begin
        $display("FAIL press_latched cycle=%0d got=%b want=1", i, bus.ns_call);
        bad++;
      end
    end
    bus.ns_served = 1'b1;
    cyc(1);
    bus.ns_served = 1'b0;
    total++;
    if (bus.ns_call !== 1'b0) begin
      $display("FAIL press_served_clear got=%b want=0", bus.ns_call);
      bad++;
    end
    cyc(3);
    total++;
    if (bus.ns_call !== 1'b0) begin
      $display("FAIL press_stays_clear got=%b want=0", bus.ns_call);
      bad++;
    end
    $display("test_clean_press done");
  endtask

  task automatic test_served_present();
    bus.ew_raw = 1'b1;
    cyc(7);
    total++;
    if (bus.ew_call !== 1'b1) begin
      $display("FAIL ew_press got=%b want=1", bus.ew_call);
      bad++;
    end
    bus.ew_served = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      total++;
      if (bus.ew_call !== 1'b1) begin
        $display("FAIL ew_served_present cycle=%0d got=%b want=1", i, bus.ew_call);
        bad++;
      end
    end
    bus.ew_served = 1'b0;
    bus.ew_raw    = 1'b0;
    cyc(10);
    total++;
    if (bus.ew_call !== 1'b1) begin
      $display("FAIL ew_latched got=%b want=1", bus.ew_call);
      bad++;
    end
    bus.ew_served = 1'b1;
    cyc(1);
    bus.ew_served = 1'b0;
    total++;
    if (bus.ew_call !== 1'b0) begin
      $display("FAIL ew_served_clear got=%b want=0", bus.ew_call);
      bad++;
    end
    $display("test_served_present done");
  endtask

  task automatic test_emergency();
    bus.emerg_raw = 1'b1;
    cyc(10);
    total++;
    if (bus.emerg_req !== 1'b1) begin
      $display("FAIL emerg_active got=%b want=1", bus.emerg_req);
      bad++;
    end
    bus.emerg_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      total++;
      if (bus.emerg_req !== 1'b1) begin
        $display("FAIL emerg_stretch cycle=%0d got=%b want=1", i, bus.emerg_req);
        bad++;
      end
    end
    tick();
    total++;
    if (bus.emerg_req !== 1'b1) begin
      $display("FAIL emerg_tick1 got=%b want=1", bus.emerg_req);
      bad++;
    end
    cyc(3);
    total++;
    if (bus.emerg_req !== 1'b1) begin
      $display("FAIL emerg_between_ticks got=%b want=1", bus.emerg_req);
      bad++;
    end
    tick();
    total++;
    if (bus.emerg_req !== 1'b0) begin
      $display("FAIL emerg_expire got=%b want=0", bus.emerg_req);
      bad++;
    end

    // Re-trigger during hold, then confirm the hold restarts from zero
    bus.emerg_raw = 1'b1;
    cyc(10);
    bus.emerg_raw = 1'b0;
    cyc(10);
    tick();
    bus.emerg_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      total++;
      if (bus.emerg_req !== 1'b1) begin
        $display("FAIL emerg_retrigger cycle=%0d got=%b want=1", i, bus.emerg_req);
        bad++;
      end
    end
    tick();
    tick();
    total++;
    if (bus.emerg_req !== 1'b1) begin
      $display("FAIL emerg_active_ignores_tick got=%b want=1", bus.emerg_req);
      bad++;
    end
    bus.emerg_raw = 1'b0;
    cyc(10);
    tick();
    total++;
    if (bus.emerg_req !== 1'b1) begin
      $display("FAIL emerg_hold_restart got=%b want=1", bus.emerg_req);
      bad++;
    end
    tick();
    total++;
    if (bus.emerg_req !== 1'b0) begin
      $display("FAIL emerg_expire2 got=%b want=0", bus.emerg_req);
      bad++;
    end
    $display("test_emergency done");
  endtask

  task automatic test_reset_mid();
    bus.ns_raw    = 1'b1;
    bus.ew_raw    = 1'b1;
    bus.emerg_raw = 1'b1;
    cyc(10);
    bus.emerg_raw = 1'b0;
    cyc(10);
    total++;
    if ({bus.ns_call, bus.ew_call, bus.emerg_req} !== 3'b111) begin
      $display("FAIL midrst_pre calls/req=%b want=111",
               {bus.ns_call, bus.ew_call, bus.emerg_req});
      bad++;
    end
    bus.ns_raw = 1'b0;
    bus.ew_raw = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.ns_call, bus.ew_call, bus.emerg_req} !== 3'b000) begin
      $display("FAIL midrst_async calls/req=%b want=000",
               {bus.ns_call, bus.ew_call, bus.emerg_req});
      bad++;
    end
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      total++;
      if ({bus.ns_call, bus.ew_call, bus.emerg_req} !== 3'b000) begin
        $display("FAIL midrst_residue cycle=%0d calls/req=%b want=000",
                 i, {bus.ns_call, bus.ew_call, bus.emerg_req});
        bad++;
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_stuck();
    exp_stuck = STUCK_EN;
    bus.ns_raw = 1'b1;
    cyc(8);
    total++;
    if (bus.ns_call !== 1'b1) begin
      $display("FAIL stuck_pre_call got=%b want=1", bus.ns_call);
      bad++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc(2);
    end
    cyc(3);
    total++;
    if (bus.ns_stuck !== exp_stuck) begin
      $display("FAIL ns_stuck got=%b want=%b", bus.ns_stuck, exp_stuck);
      bad++;
    end
    total++;
    if (bus.ew_stuck !== 1'b0) begin
      $display("FAIL ew_stuck got=%b want=0", bus.ew_stuck);
      bad++;
    end
    bus.ns_served = 1'b1;
    cyc(1);
    bus.ns_served = 1'b0;
    total++;
    if (bus.ns_call !== 1'b1) begin
      $display("FAIL stuck_served_present got=%b want=1", bus.ns_call);
      bad++;
    end
    bus.ns_raw = 1'b0;
    cyc(10);
    bus.ns_served = 1'b1;
    cyc(1);
    bus.ns_served = 1'b0;
    total++;
    if (bus.ns_call !== exp_stuck) begin
      $display("FAIL stuck_recall got=%b want=%b", bus.ns_call, exp_stuck);
      bad++;
    end
    total++;
    if (bus.ns_stuck !== exp_stuck) begin
      $display("FAIL stuck_sticky got=%b want=%b", bus.ns_stuck, exp_stuck);
      bad++;
    end
    $display("test_stuck done");
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.tick_1hz  = 1'b0;
    bus.ns_raw    = 1'b0;
    bus.ew_raw    = 1'b0;
    bus.emerg_raw = 1'b0;
    bus.ns_served = 1'b0;
    bus.ew_served = 1'b0;

    test_reset();
    test_glitch();
    test_clean_press();
    test_served_present();
    test_emergency();
    test_reset_mid();
    test_stuck();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
